// File: rtl/prod_accumulator.sv
// Frame-sum reduction stage for the multiplier product stream: accumulates unsigned
// beats with saturation, then offers the frame result on a valid/ready handshake.
module prod_accumulator #(
    parameter int IN_W    = 8,
    parameter int ACC_W   = 16,
    parameter int MAX_CNT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             sum_valid,
    input  logic             sum_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic             accept;
    logic [ACC_W-1:0] in_ext;
    logic [ACC_W:0]   add_full;
    logic [CNT_W-1:0] cnt_next;
    logic             close;

    // Handshakes: a beat moves on a rising edge with in_valid && in_ready, a result
    // moves with sum_valid && sum_ready; ready/valid outputs depend only on state.
    assign accept   = in_valid && in_ready;
    assign in_ext   = ACC_W'(in_data);
    assign add_full = {1'b0, sum} + {1'b0, in_ext};
    assign cnt_next = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
    assign close    = in_last || (cnt_next == CNT_W'(MAX_CNT));

    // in_data only reaches state under accept, so X on an idle bus never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum   <= in_ext;
                        count <= cnt_next;
                        ovf   <= 1'b0;
                        if (close) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            sum_valid <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        // Carry out of the widened add pins the sum at all-ones.
                        if (add_full[ACC_W]) begin
                            sum <= '1;
                            ovf <= 1'b1;
                        end else begin
                            sum <= add_full[ACC_W-1:0];
                        end
                        count <= cnt_next;
                        if (close) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            sum_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        sum_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    sum_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
